cache_ctrl_sa_wb: RTL and testbench

//  N-way set-associative, write-back, write-allocate data cache with multi-word lines.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_tag_cmp.sv | 34 +++
 rtl/cache_ctrl_sa_wb.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cache_ctrl_sa_wb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache controller.
package cache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_SETS           = 64;
    localparam int DEF_WAYS           = 2;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_CNT_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL,
        RESP
    } state_t;

    // Way index needs at least one bit even for a direct-mapped cache.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational tag/valid compare across all ways of one set.
module cache_tag_cmp #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 20,
    parameter int WAY_W = 1
) (
    input  logic [WAYS*TAG_W-1:0] i_tags,
    input  logic [WAYS-1:0]       i_valid,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_hit,
    output logic [WAY_W-1:0]      o_hit_way,
    output logic [WAY_W-1:0]      o_first_invalid_way,
    output logic                  o_any_invalid
);

    // Walk from the top way down so the lowest-index match/invalid wins.
    always_comb begin
        o_hit               = 1'b0;
        o_hit_way           = '0;
        o_first_invalid_way = '0;
        o_any_invalid       = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (i_valid[w] && (i_tags[w*TAG_W +: TAG_W] == i_tag)) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_W'(w);
            end
            if (!i_valid[w]) begin
                o_any_invalid       = 1'b1;
                o_first_invalid_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_sa_wb.sv
// N-way set-associative write-back / write-allocate data cache controller
// with serialised word-at-a-time victim write-back and line refill.
//
//  state  | meaning
//  IDLE   | ready for a CPU request
//  LOOKUP | tag compare; hit completes, miss picks a victim
//  WB     | writing the dirty victim line back, one word per beat
//  REFILL | reading the new line, one outstanding read at a time
//  RESP   | cpu_resp_valid pulse, then back to IDLE
module cache_ctrl_sa_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SETS           = DEF_SETS,
    parameter int WAYS           = DEF_WAYS,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cpu_req_valid,
    output logic              o_cpu_req_ready,
    input  logic              i_cpu_req_we,
    input  logic [ADDR_W-1:0] i_cpu_req_addr,
    input  logic [DATA_W-1:0] i_cpu_req_wdata,
    output logic              o_cpu_resp_valid,
    output logic [DATA_W-1:0] o_cpu_resp_rdata,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_req_we,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    output logic [DATA_W-1:0] o_mem_req_wdata,
    input  logic              i_mem_resp_valid,
    input  logic [DATA_W-1:0] i_mem_resp_rdata,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic [CNT_W-1:0]  o_miss_count
);

    localparam int SET_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - SET_W - OFF_W;
    localparam int WAY_W = clog2_min1(WAYS);

    state_t              r_state;
    logic                r_req_we;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [WAY_W-1:0]    r_victim;
    logic [OFF_W-1:0]    r_beat;
    logic                r_wait;
    logic [DATA_W-1:0]   r_fill_rdata;

    logic [DATA_W-1:0]   r_data  [SETS][WAYS][WORDS_PER_LINE];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [WAY_W-1:0]    r_rr    [SETS];

    logic [TAG_W-1:0]      w_req_tag;
    logic [SET_W-1:0]      w_req_set;
    logic [OFF_W-1:0]      w_req_off;
    logic [WAYS*TAG_W-1:0] w_set_tags;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic [WAY_W-1:0]      w_first_invalid;
    logic                  w_any_invalid;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_victim_dirty;
    logic [OFF_W-1:0]      w_zero_off;
    logic [OFF_W-1:0]      w_next_beat;
    logic                  w_last_beat;
    logic [TAG_W-1:0]      w_vic_tag;

    logic                  w_data_we;
    logic [WAY_W-1:0]      w_data_way;
    logic [OFF_W-1:0]      w_data_word;
    logic [DATA_W-1:0]     w_data_wdata;
    logic                  w_tag_we;

    assign w_req_tag   = r_req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_set   = r_req_addr[OFF_W +: SET_W];
    assign w_req_off   = r_req_addr[OFF_W-1:0];
    assign w_zero_off  = '0;
    assign w_next_beat = r_beat + 1'b1;
    assign w_last_beat = (r_beat == {OFF_W{1'b1}});
    assign w_vic_tag   = r_tag[w_req_set][r_victim];

    always_comb begin
        w_set_tags = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_set_tags[w*TAG_W +: TAG_W] = r_tag[w_req_set][w];
        end
    end

    cache_tag_cmp #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_tag_cmp (
        .i_tags              (w_set_tags),
        .i_valid             (r_valid[w_req_set]),
        .i_tag               (w_req_tag),
        .o_hit               (w_hit),
        .o_hit_way           (w_hit_way),
        .o_first_invalid_way (w_first_invalid),
        .o_any_invalid       (w_any_invalid)
    );

    assign w_victim       = w_any_invalid ? w_first_invalid : r_rr[w_req_set];
    assign w_victim_dirty = r_valid[w_req_set][w_victim] && r_dirty[w_req_set][w_victim];

    // Single write port: store hits, and refill beats with the store word merged in.
    always_comb begin
        w_data_we    = 1'b0;
        w_data_way   = r_victim;
        w_data_word  = r_beat;
        w_data_wdata = i_mem_resp_rdata;
        w_tag_we     = 1'b0;
        case (r_state)
            LOOKUP: begin
                if (w_hit && r_req_we) begin
                    w_data_we    = 1'b1;
                    w_data_way   = w_hit_way;
                    w_data_word  = w_req_off;
                    w_data_wdata = r_req_wdata;
                end
            end
            REFILL: begin
                if (r_wait && i_mem_resp_valid) begin
                    w_data_we = 1'b1;
                    w_tag_we  = w_last_beat;
                    if (r_req_we && (r_beat == w_req_off)) begin
                        w_data_wdata = r_req_wdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_data_we) begin
            r_data[w_req_set][w_data_way][w_data_word] <= w_data_wdata;
        end
        if (w_tag_we) begin
            r_tag[w_req_set][r_victim] <= w_req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_req_we         <= 1'b0;
            r_req_addr       <= '0;
            r_req_wdata      <= '0;
            r_victim         <= '0;
            r_beat           <= '0;
            r_wait           <= 1'b0;
            r_fill_rdata     <= '0;
            o_cpu_req_ready  <= 1'b1;
            o_cpu_resp_valid <= 1'b0;
            o_cpu_resp_rdata <= '0;
            o_mem_req_valid  <= 1'b0;
            o_mem_req_we     <= 1'b0;
            o_mem_req_addr   <= '0;
            o_mem_req_wdata  <= '0;
            o_hit_count      <= '0;
            o_miss_count     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            o_cpu_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cpu_req_valid) begin
                        r_req_we        <= i_cpu_req_we;
                        r_req_addr      <= i_cpu_req_addr;
                        r_req_wdata     <= i_cpu_req_wdata;
                        o_cpu_req_ready <= 1'b0;
                        r_state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (o_hit_count != {CNT_W{1'b1}}) o_hit_count <= o_hit_count + 1'b1;
                        if (r_req_we) begin
                            r_dirty[w_req_set][w_hit_way] <= 1'b1;
                            o_cpu_resp_rdata              <= '0;
                        end else begin
                            o_cpu_resp_rdata <= r_data[w_req_set][w_hit_way][w_req_off];
                        end
                        o_cpu_resp_valid <= 1'b1;
                        r_state          <= RESP;
                    end else begin
                        if (o_miss_count != {CNT_W{1'b1}}) o_miss_count <= o_miss_count + 1'b1;
                        if (!w_any_invalid) begin
                            r_rr[w_req_set] <= (WAYS == 1) ? '0 : r_rr[w_req_set] + 1'b1;
                        end
                        r_victim        <= w_victim;
                        r_beat          <= '0;
                        r_wait          <= 1'b0;
                        o_mem_req_valid <= 1'b1;
                        if (w_victim_dirty) begin
                            o_mem_req_we    <= 1'b1;
                            o_mem_req_addr  <= {r_tag[w_req_set][w_victim], w_req_set, w_zero_off};
                            o_mem_req_wdata <= r_data[w_req_set][w_victim][w_zero_off];
                            r_state         <= WB;
                        end else begin
                            o_mem_req_we    <= 1'b0;
                            o_mem_req_addr  <= {w_req_tag, w_req_set, w_zero_off};
                            o_mem_req_wdata <= '0;
                            r_state         <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (o_mem_req_valid && i_mem_req_ready) begin
                        r_beat <= w_next_beat;
                        if (w_last_beat) begin
                            o_mem_req_we    <= 1'b0;
                            o_mem_req_addr  <= {w_req_tag, w_req_set, w_zero_off};
                            o_mem_req_wdata <= '0;
                            r_wait          <= 1'b0;
                            r_state         <= REFILL;
                        end else begin
                            o_mem_req_addr  <= {w_vic_tag, w_req_set, w_next_beat};
                            o_mem_req_wdata <= r_data[w_req_set][r_victim][w_next_beat];
                        end
                    end
                end
                REFILL: begin
                    if (!r_wait) begin
                        if (i_mem_req_ready) begin
                            o_mem_req_valid <= 1'b0;
                            r_wait          <= 1'b1;
                        end
                    end else if (i_mem_resp_valid) begin
                        if (r_beat == w_req_off) r_fill_rdata <= i_mem_resp_rdata;
                        r_wait <= 1'b0;
                        r_beat <= w_next_beat;
                        if (w_last_beat) begin
                            r_valid[w_req_set][r_victim] <= 1'b1;
                            r_dirty[w_req_set][r_victim] <= r_req_we;
                            if (r_req_we) begin
                                o_cpu_resp_rdata <= '0;
                            end else if (r_beat == w_req_off) begin
                                o_cpu_resp_rdata <= i_mem_resp_rdata;
                            end else begin
                                o_cpu_resp_rdata <= r_fill_rdata;
                            end
                            o_cpu_resp_valid <= 1'b1;
                            r_state          <= RESP;
                        end else begin
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_addr  <= {w_req_tag, w_req_set, w_next_beat};
                        end
                    end
                end
                RESP: begin
                    o_cpu_req_ready <= 1'b1;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_sa_wb.sv
// Directed self-checking bench for cache_ctrl_sa_wb with a small word-addressed memory model.
module tb_cache_ctrl_sa_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_cpu_req_valid = 1'b0;
    logic        o_cpu_req_ready;
    logic        i_cpu_req_we = 1'b0;
    logic [15:0] i_cpu_req_addr = '0;
    logic [31:0] i_cpu_req_wdata = '0;
    logic        o_cpu_resp_valid;
    logic [31:0] o_cpu_resp_rdata;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b1;
    logic        o_mem_req_we;
    logic [15:0] o_mem_req_addr;
    logic [31:0] o_mem_req_wdata;
    logic        i_mem_resp_valid = 1'b0;
    logic [31:0] i_mem_resp_rdata = '0;
    logic [31:0] o_hit_count;
    logic [31:0] o_miss_count;

    cache_ctrl_sa_wb #(
        .ADDR_W(16), .DATA_W(32), .SETS(4), .WAYS(2), .WORDS_PER_LINE(4), .CNT_W(32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_cpu_req_valid  (i_cpu_req_valid),
        .o_cpu_req_ready  (o_cpu_req_ready),
        .i_cpu_req_we     (i_cpu_req_we),
        .i_cpu_req_addr   (i_cpu_req_addr),
        .i_cpu_req_wdata  (i_cpu_req_wdata),
        .o_cpu_resp_valid (o_cpu_resp_valid),
        .o_cpu_resp_rdata (o_cpu_resp_rdata),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_we     (o_mem_req_we),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_wdata  (o_mem_req_wdata),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_rdata (i_mem_resp_rdata),
        .o_hit_count      (o_hit_count),
        .o_miss_count     (o_miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model: initial contents 0x1000_0000 | address.
    logic [31:0] mem [0:65535];
    logic [15:0] log_addr[$];
    logic        log_we[$];
    logic        resp_pend = 1'b0;
    logic [15:0] resp_addr = '0;
    logic        stall_arm = 1'b0;
    logic        stall_seen = 1'b0;
    int          stall_left = 0;
    logic [15:0] stall_exp_addr = '0;
    logic [31:0] stall_exp_wdata = '0;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h1000_0000 | 32'(a);
    end

    // All memory-side driving happens on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        i_mem_resp_valid = 1'b0;
        if (reset) begin
            resp_pend       = 1'b0;
            i_mem_req_ready = 1'b1;
        end else begin
            if (resp_pend) begin
                i_mem_resp_valid = 1'b1;
                i_mem_resp_rdata = mem[resp_addr];
                resp_pend        = 1'b0;
            end
            if (stall_arm && o_mem_req_valid && o_mem_req_we && o_mem_req_addr == stall_exp_addr) begin
                stall_arm  = 1'b0;
                stall_seen = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                i_mem_req_ready = 1'b0;
                check("wb_stall_addr", o_mem_req_addr, stall_exp_addr);
                check("wb_stall_wdata", o_mem_req_wdata, stall_exp_wdata);
                i_mem_resp_valid = 1'b1;
                i_mem_resp_rdata = 32'hDEAD_BEEF;
                stall_left--;
            end else begin
                i_mem_req_ready = 1'b1;
            end
            if (o_mem_req_valid && i_mem_req_ready) begin
                log_addr.push_back(o_mem_req_addr);
                log_we.push_back(o_mem_req_we);
                if (o_mem_req_we) mem[o_mem_req_addr] = o_mem_req_wdata;
                else begin
                    resp_pend = 1'b1;
                    resp_addr = o_mem_req_addr;
                end
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output int lat);
        int n;
        n = 0;
        while (!o_cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        i_cpu_req_valid = 1'b1;
        i_cpu_req_we    = we;
        i_cpu_req_addr  = addr;
        i_cpu_req_wdata = wd;
        @(negedge clk);
        i_cpu_req_valid = 1'b0;
        lat = 1;
        while (!o_cpu_resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!o_cpu_resp_valid) check("resp_timeout", 0, 1);
        rd = o_cpu_resp_rdata;
    endtask

    task automatic check_burst(input string tag, input int first, input logic [15:0] base, input logic we);
        for (int i = 0; i < 4; i++) begin
            check(tag, {log_we[first+i], log_addr[first+i]}, {we, base + 16'(i)});
        end
    endtask

    function automatic int count_writes();
        int c = 0;
        foreach (log_we[k]) if (log_we[k]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          n;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", o_cpu_req_ready, 1);
        check("rst_resp_valid", o_cpu_resp_valid, 0);
        check("rst_mem_valid", o_mem_req_valid, 0);
        check("rst_hit_cnt", o_hit_count, 0);
        check("rst_miss_cnt", o_miss_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss then store/load hits in the same line
        clear_log();
        cpu_access(1'b0, 16'h0010, 32'h0, rd, lat);
        check("a_miss_rdata", rd, 32'h1000_0010);
        check("a_miss_cnt", o_miss_count, 1);
        check("a_refill_len", log_addr.size(), 4);
        check_burst("a_refill", 0, 16'h0010, 1'b0);

        clear_log();
        cpu_access(1'b1, 16'h0011, 32'h0000_CAFE, rd, lat);
        check("a_st_lat", lat, 2);
        check("a_st_rdata", rd, 0);
        cpu_access(1'b0, 16'h0011, 32'h0, rd, lat);
        check("a_ld_lat", lat, 2);
        check("a_ld_rdata", rd, 32'h0000_CAFE);
        check("a_hit_cnt", o_hit_count, 2);
        check("a_no_traffic", log_addr.size(), 0);

        // Dirty victim write-back, with a stall and stray responses mid-burst
        do_reset();
        cpu_access(1'b0, 16'h0000, 32'h0, rd, lat);
        cpu_access(1'b1, 16'h0002, 32'h0000_BEEF, rd, lat);
        check("b_st_lat", lat, 2);
        cpu_access(1'b0, 16'h0010, 32'h0, rd, lat);
        clear_log();
        stall_exp_addr  = 16'h0002;
        stall_exp_wdata = 32'h0000_BEEF;
        stall_arm       = 1'b1;
        cpu_access(1'b0, 16'h0020, 32'h0, rd, lat);
        check("b_rdata", rd, 32'h1000_0020);
        check("b_stall_seen", stall_seen, 1);
        check("b_log_len", log_addr.size(), 8);
        check_burst("b_wb", 0, 16'h0000, 1'b1);
        check_burst("b_refill", 4, 16'h0020, 1'b0);
        check("b_wb_word2", mem[16'h0002], 32'h0000_BEEF);
        check("b_wb_word1", mem[16'h0001], 32'h1000_0001);
        check("b_miss_cnt", o_miss_count, 3);
        check("b_hit_cnt", o_hit_count, 1);

        // Clean victims: no write-back, RR alternates 1 -> 0 -> 1 -> 0
        clear_log();
        cpu_access(1'b0, 16'h0030, 32'h0, rd, lat);
        check("c_ld30_rdata", rd, 32'h1000_0030);
        cpu_access(1'b0, 16'h0021, 32'h0, rd, lat);
        check("c_ld21_hit", lat, 2);
        check("c_ld21_rdata", rd, 32'h1000_0021);
        cpu_access(1'b0, 16'h0043, 32'h0, rd, lat);
        check("c_ld43_rdata", rd, 32'h1000_0043);
        cpu_access(1'b0, 16'h0032, 32'h0, rd, lat);
        check("c_ld32_hit", lat, 2);
        cpu_access(1'b0, 16'h0020, 32'h0, rd, lat);
        check("c_ld20_miss", lat > 2, 1);
        check("c_no_writes", count_writes(), 0);
        check("c_reads", log_addr.size(), 12);
        check("c_miss_cnt", o_miss_count, 6);
        check("c_hit_cnt", o_hit_count, 3);

        // Reset during refill beat 2
        n = 0;
        while (!o_cpu_req_ready && n < 100) begin @(negedge clk); n++; end
        i_cpu_req_valid = 1'b1;
        i_cpu_req_we    = 1'b0;
        i_cpu_req_addr  = 16'h0050;
        @(negedge clk);
        i_cpu_req_valid = 1'b0;
        n = 0;
        while (!(o_mem_req_valid && !o_mem_req_we && o_mem_req_addr == 16'h0052) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("d_beat2_seen", n < 100, 1);
        reset = 1'b1;
        #1;
        check("d_rst_mem_valid", o_mem_req_valid, 0);
        check("d_rst_mem_addr", o_mem_req_addr, 0);
        check("d_rst_ready", o_cpu_req_ready, 1);
        check("d_rst_miss_cnt", o_miss_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("d_pre_hit_cnt", o_hit_count, 0);
        check("d_pre_miss_cnt", o_miss_count, 0);
        clear_log();
        cpu_access(1'b0, 16'h0050, 32'h0, rd, lat);
        check("d_rdata", rd, 32'h1000_0050);
        check("d_miss_cnt", o_miss_count, 1);
        check("d_hit_cnt", o_hit_count, 0);
        check("d_refill_len", log_addr.size(), 4);
        check_burst("d_refill", 0, 16'h0050, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
